// File: rtl/fp_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_mul_pkg
//  Description : Shared constants and helpers for the small-float multiplier
//                scheduling slice. Holds the supported operand widths, the
//                encodings of 1.0 in each format, and a ceil(log2) helper
//                used to size the round-robin pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_mul_pkg;

    // Supported operand widths
    localparam int WIDTH_BF16 = 16;
    localparam int WIDTH_E4M3 = 8;

    // Encodings of +1.0
    localparam logic [15:0] BF16_ONE = 16'h3F80;
    localparam logic [7:0]  E4M3_ONE = 8'h38;

    // Number of bits needed to index n requesters (at least 1).
    function automatic int clog2_req(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage : fp_mul_pkg
`default_nettype wire

// File: rtl/fp_mul_rr_scheduler_arb.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter. The scan starts at the pointer and
//                wraps modulo NUM_REQ; the first asserted request wins. After
//                a grant to requester i the pointer moves to (i+1) mod
//                NUM_REQ; with no grant it holds. Grants are only issued
//                while en is high, so the pointer is frozen otherwise.
//  Ports       : clock     - system clock, rising edge
//                reset     - asynchronous active-low reset (pointer -> 0)
//                en        - grant enable
//                req       - per-requester request
//                grant     - one-hot grant (or zero)
//                grant_id  - index of the granted requester
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import fp_mul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    localparam int c_PTR_W = clog2_req(NUM_REQ);

    logic [c_PTR_W-1:0] r_ptr;
    logic [c_PTR_W-1:0] w_next_ptr;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_id;
    logic               w_found;
    int                 w_idx;

    function automatic int wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return s;
    endfunction

    // Walk offsets from the pointer; the inner loop keeps every bit select
    // on a constant index.
    always_comb begin
        w_grant    = '0;
        w_grant_id = '0;
        w_next_ptr = r_ptr;
        w_found    = 1'b0;
        w_idx      = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_idx = wrap_idx(int'(r_ptr), off);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (en && !w_found && (i == w_idx) && req[i]) begin
                    w_found    = 1'b1;
                    w_grant[i] = 1'b1;
                    w_grant_id = ID_W'(i);
                    w_next_ptr = (i == NUM_REQ - 1) ? '0 : c_PTR_W'(i + 1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= w_next_ptr;
        end
    end

    assign grant    = w_grant;
    assign grant_id = w_grant_id;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/fp_mul_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : fp_mul_rr_scheduler
//  Description : Shares one combinational float multiplier between NUM_REQ
//                requesters. Round-robin arbitration feeds a two-stage
//                registered pipeline: S1 holds {a, b, id} and drives the
//                external multiplier through mul_a/mul_b, S2 captures mul_y
//                and the id and presents them as the response. Both sides
//                use valid/ready handshakes; flush discards in-flight work.
//  Ports       : clock, reset (async active-low)
//                req_valid/req_ready/req_a/req_b - requester side
//                flush                           - synchronous discard
//                mul_a/mul_b/mul_y               - external multiplier
//                resp_valid/resp_ready/resp_y/resp_id - response side
//                busy                            - S1 or S2 occupied
//  Options     : FP_MUL_SCHED_STATS_EN adds grant_cnt (per-requester
//                saturating grant counters) and stall_cnt (saturating count
//                of cycles with resp_valid & ~resp_ready).
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_rr_scheduler
    import fp_mul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = WIDTH_BF16,
    parameter int ID_W    = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic                     flush,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic [WIDTH-1:0]         mul_y,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [WIDTH-1:0]         resp_y,
    output logic [ID_W-1:0]          resp_id,
    output logic                     busy
`ifdef FP_MUL_SCHED_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]    grant_cnt,
    output logic [15:0]              stall_cnt
`endif
);

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic              r_s1_v;
    logic [WIDTH-1:0]  r_s1_a;
    logic [WIDTH-1:0]  r_s1_b;
    logic [ID_W-1:0]   r_s1_id;

    logic              r_s2_v;
    logic [WIDTH-1:0]  r_s2_y;
    logic [ID_W-1:0]   r_s2_id;

    logic              w_s2_adv;
    logic              w_s1_free;
    logic              w_arb_en;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]   w_grant_id;
    logic              w_take;
    logic [WIDTH-1:0]  w_sel_a;
    logic [WIDTH-1:0]  w_sel_b;

    // S1 moves into S2 whenever S2 is empty or draining this edge, which
    // in turn frees S1 for a new grant on the same edge.
    assign w_s2_adv  = r_s1_v & (~r_s2_v | resp_ready);
    assign w_s1_free = ~r_s1_v | w_s2_adv;
    // Reset level is folded in so no requester sees ready while held in reset.
    assign w_arb_en  = w_s1_free & ~flush & reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clock    (clock),
        .reset    (reset),
        .en       (w_arb_en),
        .req      (req_valid),
        .grant    (w_grant),
        .grant_id (w_grant_id)
    );

    // Grants only go to asserted requests, so any grant is a transfer.
    assign w_take    = |w_grant;
    assign req_ready = w_grant;

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a = req_a[i*WIDTH +: WIDTH];
                w_sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // S1: operands and tag, drives the multiplier
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1_v  <= 1'b0;
            r_s1_a  <= '0;
            r_s1_b  <= '0;
            r_s1_id <= '0;
        end else if (flush) begin
            r_s1_v  <= 1'b0;
        end else if (w_take) begin
            r_s1_v  <= 1'b1;
            r_s1_a  <= w_sel_a;
            r_s1_b  <= w_sel_b;
            r_s1_id <= w_grant_id;
        end else if (w_s2_adv) begin
            r_s1_v  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // S2: product and tag, presented as the response
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s2_v  <= 1'b0;
            r_s2_y  <= '0;
            r_s2_id <= '0;
        end else if (flush) begin
            r_s2_v  <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_v  <= 1'b1;
            r_s2_y  <= mul_y;
            r_s2_id <= r_s1_id;
        end else if (resp_ready) begin
            r_s2_v  <= 1'b0;
        end
    end

    assign mul_a      = r_s1_a;
    assign mul_b      = r_s1_b;
    assign resp_valid = r_s2_v;
    assign resp_y     = r_s2_y;
    assign resp_id    = r_s2_id;
    assign busy       = r_s1_v | r_s2_v;

`ifdef FP_MUL_SCHED_STATS_EN
    // ------------------------------------------------------------------
    // Statistics counters, saturating at all-ones, untouched by flush
    // ------------------------------------------------------------------
    logic [15:0] r_grant_cnt [NUM_REQ];
    logic [15:0] r_stall_cnt;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_grant_cnt[gi] <= '0;
                end else if (w_grant[gi] && (r_grant_cnt[gi] != 16'hFFFF)) begin
                    r_grant_cnt[gi] <= r_grant_cnt[gi] + 16'd1;
                end
            end
            assign grant_cnt[gi*16 +: 16] = r_grant_cnt[gi];
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (r_s2_v && !resp_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule : fp_mul_rr_scheduler
`default_nettype wire

// File: tb/tb_fp_mul_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_mul_rr_scheduler
//  Description : Self-checking bench for fp_mul_rr_scheduler (4 requesters,
//                bf16). A behavioural bf16 multiplier is attached to the
//                mul_* ports. Expected grants come from a round-robin pick
//                over an integer pointer; expected responses come from a
//                queue of products of accepted operands.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mul_rr_scheduler;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 16;
    localparam int ID_W    = 2;

    logic                     clock;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     flush;
    logic [WIDTH-1:0]         mul_a;
    logic [WIDTH-1:0]         mul_b;
    logic [WIDTH-1:0]         mul_y;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [WIDTH-1:0]         resp_y;
    logic [ID_W-1:0]          resp_id;
    logic                     busy;
`ifdef FP_MUL_SCHED_STATS_EN
    logic [NUM_REQ*16-1:0]    grant_cnt;
    logic [15:0]              stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;
    logic [15:0] exp_y [$];
    int          exp_id [$];

    fp_mul_rr_scheduler #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .ID_W    (ID_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .flush      (flush),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_y      (mul_y),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_y     (resp_y),
        .resp_id    (resp_id),
        .busy       (busy)
`ifdef FP_MUL_SCHED_STATS_EN
        ,
        .grant_cnt  (grant_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural bf16 multiply: truncating, zero/subnormal inputs give a
    // signed zero, exponent overflow gives infinity.
    function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        int          ea, eb, e;
        logic [15:0] p;
        logic [6:0]  m;
        s  = a[15] ^ b[15];
        ea = int'(a[14:7]);
        eb = int'(b[14:7]);
        if (ea == 0 || eb == 0) return {s, 15'h0};
        p = {8'h0, 1'b1, a[6:0]} * {8'h0, 1'b1, b[6:0]};
        e = ea + eb - 127;
        if (p[15]) begin
            m = p[14:8];
            e = e + 1;
        end else begin
            m = p[13:7];
        end
        if (e <= 0)   return {s, 15'h0};
        if (e >= 255) return {s, 8'hFF, 7'h0};
        return {s, e[7:0], m};
    endfunction

    assign mul_y = bf16_mul(mul_a, mul_b);

    // Round-robin choice: first valid at or after ptr, wrapping; -1 if none.
    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int off = 0; off < NUM_REQ; off++) begin
            if (v[(ptr + off) % NUM_REQ]) return (ptr + off) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int idx);
        logic [NUM_REQ-1:0] r;
        r = '0;
        if (idx >= 0) r[idx] = 1'b1;
        return r;
    endfunction

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] g);
        for (int i = 0; i < NUM_REQ; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic accept(input int idx);
        exp_y.push_back(bf16_mul(req_a[idx*WIDTH +: WIDTH], req_b[idx*WIDTH +: WIDTH]));
        exp_id.push_back(idx);
        m_ptr = (idx + 1) % NUM_REQ;
    endtask

    task automatic randomize_operands();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = 16'($urandom_range(0, 65535));
            req_b[i*WIDTH +: WIDTH] = 16'($urandom_range(0, 65535));
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        #3;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: resp_valid=%b busy=%b req_ready=%b, required 0 0 0000",
                     resp_valid, busy, req_ready);
        end
        checks++;
        if (mul_a !== '0 || mul_b !== '0 || resp_y !== '0 || resp_id !== '0) begin
            errors++;
            $display("FAIL reset_data: mul_a=%h mul_b=%h resp_y=%h resp_id=%0d, required all 0",
                     mul_a, mul_b, resp_y, resp_id);
        end
        @(negedge clock);
        reset = 1'b1;
        m_ptr = 0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_rr_order();
        int exp_g;
        randomize_operands();
        resp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            req_valid = '1;
            #1;
            exp_g = rr_pick(req_valid, m_ptr);
            checks++;
            if (req_ready !== onehot(c % NUM_REQ) || exp_g != c % NUM_REQ) begin
                errors++;
                $display("FAIL rr_order grant %0d: req_ready=%b, required %b", c, req_ready, onehot(c % NUM_REQ));
            end
            if (c >= 2) begin
                checks++;
                if (resp_valid !== 1'b1 || resp_id !== ID_W'(exp_id[0]) || resp_y !== exp_y[0]) begin
                    errors++;
                    $display("FAIL rr_order resp %0d: valid=%b id=%0d y=%h, required 1 %0d %h",
                             c, resp_valid, resp_id, resp_y, exp_id[0], exp_y[0]);
                end
                if (resp_valid) begin
                    void'(exp_y.pop_front());
                    void'(exp_id.pop_front());
                end
            end
            accept(c % NUM_REQ);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            req_valid = '0;
            #1;
            if (resp_valid) begin
                checks++;
                if (exp_y.size() == 0 || resp_id !== ID_W'(exp_id[0]) || resp_y !== exp_y[0]) begin
                    errors++;
                    $display("FAIL rr_order drain: id=%0d y=%h, unexpected or wrong", resp_id, resp_y);
                end
                if (exp_y.size() > 0) begin
                    void'(exp_y.pop_front());
                    void'(exp_id.pop_front());
                end
            end
        end
        checks++;
        if (exp_y.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_order empty: outstanding=%0d busy=%b, required 0 0", exp_y.size(), busy);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_single();
        step();
        req_valid = 4'b0010;
        req_a[1*WIDTH +: WIDTH] = 16'h3FC0;
        req_b[1*WIDTH +: WIDTH] = 16'h4000;
        resp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL single_grant: req_ready=%b, required 0010", req_ready);
        end
        m_ptr = 2;
        step();
        req_valid = '0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b1 || mul_a !== 16'h3FC0 || mul_b !== 16'h4000) begin
            errors++;
            $display("FAIL single_s1: resp_valid=%b busy=%b mul_a=%h mul_b=%h, required 0 1 3fc0 4000",
                     resp_valid, busy, mul_a, mul_b);
        end
        step();
        #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_y !== 16'h4040 || resp_id !== 2'd1) begin
            errors++;
            $display("FAIL single_resp: valid=%b y=%h id=%0d, required 1 4040 1", resp_valid, resp_y, resp_id);
        end
        step();
        #1;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: resp_valid=%b busy=%b, required 0 0", resp_valid, busy);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_wrap();
        logic [NUM_REQ-1:0] seq_v [4];
        int                 seq_g [4];
        seq_v[0] = 4'b0100; seq_g[0] = 2;   // moves ptr to 3
        seq_v[1] = 4'b1001; seq_g[1] = 3;
        seq_v[2] = 4'b0001; seq_g[2] = 0;   // wrap
        seq_v[3] = 4'b1011; seq_g[3] = 1;   // ptr came back to 1
        randomize_operands();
        resp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            req_valid = seq_v[c];
            #1;
            checks++;
            if (req_ready !== onehot(seq_g[c]) || rr_pick(seq_v[c], m_ptr) != seq_g[c]) begin
                errors++;
                $display("FAIL wrap step %0d: req_ready=%b, required %b", c, req_ready, onehot(seq_g[c]));
            end
            if (resp_valid) begin
                void'(exp_y.pop_front());
                void'(exp_id.pop_front());
            end
            accept(seq_g[c]);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            req_valid = '0;
            #1;
            if (resp_valid) begin
                checks++;
                if (exp_y.size() == 0 || resp_id !== ID_W'(exp_id[0]) || resp_y !== exp_y[0]) begin
                    errors++;
                    $display("FAIL wrap drain: id=%0d y=%h, unexpected or wrong", resp_id, resp_y);
                end
                if (exp_y.size() > 0) begin
                    void'(exp_y.pop_front());
                    void'(exp_id.pop_front());
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_backpressure();
        int          acc;
        logic        held;
        logic [15:0] held_y;
        logic [1:0]  held_id;
        acc  = 0;
        held = 1'b0;
        held_y  = '0;
        held_id = '0;
        randomize_operands();
        for (int c = 0; c < 5; c++) begin
            step();
            req_valid  = '1;
            resp_ready = 1'b0;
            #1;
            if (|req_ready) begin
                checks++;
                if (req_ready !== onehot(rr_pick(req_valid, m_ptr))) begin
                    errors++;
                    $display("FAIL bp_grant: req_ready=%b, required %b", req_ready, onehot(rr_pick(req_valid, m_ptr)));
                end
                acc++;
                accept(onehot_idx(req_ready));
            end
            if (resp_valid && held) begin
                checks++;
                if (resp_y !== held_y || resp_id !== held_id) begin
                    errors++;
                    $display("FAIL bp_stable: y=%h id=%0d, required %h %0d", resp_y, resp_id, held_y, held_id);
                end
            end else if (resp_valid) begin
                held    = 1'b1;
                held_y  = resp_y;
                held_id = resp_id;
            end
        end
        checks++;
        if (acc != 2 || !held) begin
            errors++;
            $display("FAIL bp_accepted: accepted=%0d resp_seen=%b, required 2 1", acc, held);
        end
        for (int c = 0; c < 5; c++) begin
            step();
            req_valid  = '0;
            resp_ready = 1'b1;
            #1;
            if (resp_valid) begin
                checks++;
                if (exp_y.size() == 0 || resp_id !== ID_W'(exp_id[0]) || resp_y !== exp_y[0]) begin
                    errors++;
                    $display("FAIL bp_drain: id=%0d y=%h, unexpected or wrong", resp_id, resp_y);
                end
                if (exp_y.size() > 0) begin
                    void'(exp_y.pop_front());
                    void'(exp_id.pop_front());
                end
            end
        end
        checks++;
        if (exp_y.size() != 0) begin
            errors++;
            $display("FAIL bp_empty: outstanding=%0d, required 0", exp_y.size());
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_flush();
        randomize_operands();
        for (int c = 0; c < 2; c++) begin
            step();
            req_valid  = '1;
            resp_ready = 1'b0;
            #1;
            if (|req_ready) accept(onehot_idx(req_ready));
        end
        step();
        flush = 1'b1;
        #1;
        checks++;
        if (req_ready !== '0 || busy !== 1'b1 || resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_cycle: req_ready=%b busy=%b resp_valid=%b, required 0000 1 1",
                     req_ready, busy, resp_valid);
        end
        step();
        flush      = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_after: resp_valid=%b busy=%b, required 0 0", resp_valid, busy);
        end
        exp_y.delete();
        exp_id.delete();
        for (int c = 0; c < 2; c++) begin
            step();
            #1;
            checks++;
            if (resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_stale: resp_valid=%b, required 0", resp_valid);
            end
        end
        // Pointer must be the one left by the last real grant.
        step();
        req_valid = '1;
        #1;
        checks++;
        if (req_ready !== onehot(m_ptr)) begin
            errors++;
            $display("FAIL flush_ptr: req_ready=%b, required %b", req_ready, onehot(m_ptr));
        end
        if (|req_ready) accept(onehot_idx(req_ready));
        for (int c = 0; c < 3; c++) begin
            step();
            req_valid = '0;
            #1;
            if (resp_valid) begin
                checks++;
                if (exp_y.size() == 0 || resp_id !== ID_W'(exp_id[0]) || resp_y !== exp_y[0]) begin
                    errors++;
                    $display("FAIL flush_drain: id=%0d y=%h, unexpected or wrong", resp_id, resp_y);
                end
                if (exp_y.size() > 0) begin
                    void'(exp_y.pop_front());
                    void'(exp_id.pop_front());
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_async_reset();
        randomize_operands();
        resp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            req_valid = '1;
            #1;
            if (|req_ready) accept(onehot_idx(req_ready));
        end
        step();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL areset_drop: resp_valid=%b busy=%b req_ready=%b, required 0 0 0000",
                     resp_valid, busy, req_ready);
        end
        #1;
        reset = 1'b1;
        exp_y.delete();
        exp_id.delete();
        m_ptr = 0;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL areset_first: req_ready=%b, required 0001", req_ready);
        end
        if (|req_ready) accept(onehot_idx(req_ready));
        for (int c = 0; c < 3; c++) begin
            step();
            req_valid = '0;
            #1;
            if (resp_valid) begin
                checks++;
                if (exp_y.size() == 0 || resp_id !== ID_W'(exp_id[0]) || resp_y !== exp_y[0]) begin
                    errors++;
                    $display("FAIL areset_drain: id=%0d y=%h, unexpected or wrong", resp_id, resp_y);
                end
                if (exp_y.size() > 0) begin
                    void'(exp_y.pop_front());
                    void'(exp_id.pop_front());
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random_stream();
        logic [NUM_REQ-1:0] done_prev;
        logic [NUM_REQ-1:0] exp_g;
        int                 grants;
        done_prev = '1;
        grants    = 0;
        req_valid = '0;
        for (int c = 0; c < 400; c++) begin
            step();
            // Requesters hold operands until accepted, then may re-present.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (done_prev[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 1) == 1);
                    req_a[i*WIDTH +: WIDTH] = 16'($urandom_range(0, 65535));
                    req_b[i*WIDTH +: WIDTH] = 16'($urandom_range(0, 65535));
                end
            end
            resp_ready = ($urandom_range(0, 9) < 7);
            #1;
            // A slot opens if fewer than two ops are in flight or one drains.
            exp_g = '0;
            if (exp_y.size() < 2 || resp_ready) exp_g = onehot(rr_pick(req_valid, m_ptr));
            checks++;
            if (req_ready !== exp_g) begin
                errors++;
                $display("FAIL rand_grant cyc %0d: req_ready=%b, required %b", c, req_ready, exp_g);
            end
            if (resp_valid) begin
                checks++;
                if (exp_y.size() == 0 || resp_id !== ID_W'(exp_id[0]) || resp_y !== exp_y[0]) begin
                    errors++;
                    $display("FAIL rand_resp cyc %0d: id=%0d y=%h, unexpected or wrong", c, resp_id, resp_y);
                end
                if (resp_ready && exp_y.size() > 0) begin
                    void'(exp_y.pop_front());
                    void'(exp_id.pop_front());
                end
            end
            done_prev = req_ready;
            if (|req_ready) begin
                grants++;
                accept(onehot_idx(req_ready));
            end
        end
        for (int c = 0; c < 6; c++) begin
            step();
            req_valid  = '0;
            resp_ready = 1'b1;
            #1;
            if (resp_valid) begin
                checks++;
                if (exp_y.size() == 0 || resp_id !== ID_W'(exp_id[0]) || resp_y !== exp_y[0]) begin
                    errors++;
                    $display("FAIL rand_drain: id=%0d y=%h, unexpected or wrong", resp_id, resp_y);
                end
                if (exp_y.size() > 0) begin
                    void'(exp_y.pop_front());
                    void'(exp_id.pop_front());
                end
            end
        end
        checks++;
        if (exp_y.size() != 0 || busy !== 1'b0 || grants < 50) begin
            errors++;
            $display("FAIL rand_end: outstanding=%0d busy=%b grants=%0d, required 0 0 >=50",
                     exp_y.size(), busy, grants);
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        reset      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        flush      = 1'b0;
        resp_ready = 1'b0;
        test_reset();
        test_rr_order();
        test_single();
        test_wrap();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

endmodule : tb_fp_mul_rr_scheduler
`default_nettype wire

// File: doc/fp_mul_rr_scheduler.md
Name: fp_mul_rr_scheduler

Overview:
- Shares one combinational float multiplier (bf16 by default, e4m3 with WIDTH=8) between NUM_REQ requesters.
- Uses round-robin arbitration, a two-stage registered pipeline, and valid/ready handshakes on both sides.
- Returns each product tagged with the requester index.
- Sits between compute clients and a float_multiplier_* instance, which connects through the mul_* ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 16, operand/result width (16 = bf16, 8 = e4m3)
- ID_W, 2, width of requester tag; must be >= clog2(NUM_REQ)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_a  in  NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B, same packing
- flush  in  1  synchronous discard of all in-flight operations
- mul_a  out  WIDTH  operand A to multiplier (S1 register)
- mul_b  out  WIDTH  operand B to multiplier (S1 register)
- mul_y  in  WIDTH  multiplier result, combinational from mul_a/mul_b
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accept
- resp_y  out  WIDTH  product
- resp_id  out  ID_W  index of originating requester
- busy  out  1  S1 or S2 occupied

Behaviour:
- Reset (reset=0, asynchronous):
  - S1/S2 valid cleared; mul_a=mul_b=0; resp_valid=0; resp_y=0; resp_id=0.
  - Round-robin pointer = 0; busy=0; req_ready=0.
- Pipeline:
  - S1 holds {a, b, id} and drives the multiplier.
  - S2 captures mul_y and id.
  - s2_adv = s1_v & (~s2_v | resp_ready).
  - s1_free = ~s1_v | s2_adv.
- Arbitration:
  - Combinational, only while s1_free and flush=0.
  - Scan starts at ptr and wraps modulo NUM_REQ; the first asserted req_valid gets req_ready.
  - A transfer happens when req_valid[i] & req_ready[i]; operands and id are loaded into S1 on that edge.
  - After a grant to i, ptr <= (i+1) mod NUM_REQ; ptr = NUM_REQ-1 wraps to 0. No grant means ptr holds.
- Latency and throughput:
  - Accept at edge k: S1 valid after k, resp_valid after k+1 if unstalled.
  - Sustains 1 op/clock with resp_ready=1.
- Backpressure:
  - With resp_valid=1 and resp_ready=0, S2 holds resp_y/resp_id stable.
  - S1 holds; req_ready is 0 for all requesters while S1 is full and cannot advance.
- Simultaneous events:
  - S2 draining and S1 moving into S2 on the same edge is allowed.
  - A new grant into S1 on that same edge is allowed.
- Flush (synchronous):
  - Clears S1/S2 valid next edge; no req_ready that cycle; ptr unchanged.
  - Flush has priority over all transfers; discarded responses never appear.
- Reset mid-operation: in-flight results are lost and no response is emitted; requesters re-present.
- The multiplier path is purely combinational; the block never inspects operand encoding (zero/sign handling belongs to the multiplier).
- Requester rule: req_a/req_b must be stable while req_valid=1 and req_ready=0.
- busy = s1_v | s2_v.

Optional Feature:
- Macro FP_MUL_SCHED_STATS_EN.
- When defined:
  - Adds output grant_cnt (NUM_REQ*16): per-requester saturating 16-bit grant counters (stick at 16'hFFFF).
  - Adds output stall_cnt (16): saturating count of cycles with resp_valid & ~resp_ready.
  - All counters reset to 0; flush does not clear them.
- When undefined: these ports and registers are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package fp_mul_pkg:
  - Format width constants WIDTH_BF16=16 and WIDTH_E4M3=8.
  - Constants BF16_ONE=16'h3F80 and E4M3_ONE=8'h38.
  - Function for clog2 of NUM_REQ.
- One natural sub-module, rr_arbiter: NUM_REQ request in, one-hot grant out, ptr register, enable input (s1_free & ~flush).
- Pipeline registers stay in the top level.

Test Plan:
- Single request: requester 1 sends a=16'h3FC0, b=16'h4000 with float_multiplier_bf16 attached → req_ready[1] same cycle; resp_valid two edges later with resp_y=16'h4040, resp_id=1.
- Four requesters all valid continuously, resp_ready=1 → grants in order 0,1,2,3,0; one response per clock; resp_ids match grant order.
- ptr=3, only requester 3 and 0 valid → grant 3, then 0 (wrap); ptr returns to 1.
- resp_ready=0 for 5 cycles with back-to-back requests → at most 2 ops accepted; resp_y/resp_id stable; drain in order once resp_ready=1.
- Flush asserted with S1 and S2 full → resp_valid=0 next cycle; no stale response afterwards; busy=0.
- Async reset pulse mid-stream with no clock edge → resp_valid and busy drop immediately; after release, first grant goes to requester 0.
